// File: rtl/axi_master_arbiter_if.sv
// Bundle for the N requester-side AXI3 channels and the single shared core-side AXI3 master port.
// The master modport is the arbiter's view; slave is the surrounding environment.
interface axi_master_arbiter_if #(
    parameter int unsigned N = 2
);
    logic [N-1:0]    s_arvalid, s_arready;
    logic [N*32-1:0] s_araddr;
    logic [N*4-1:0]  s_arlen;
    logic [N*3-1:0]  s_arsize;
    logic [N-1:0]    s_rvalid, s_rready;
    logic [31:0]     s_rdata;
    logic [1:0]      s_rresp;
    logic            s_rlast;
    logic [N-1:0]    s_awvalid, s_awready;
    logic [N*32-1:0] s_awaddr;
    logic [N*4-1:0]  s_awlen;
    logic [N*3-1:0]  s_awsize;
    logic [N-1:0]    s_wvalid, s_wready;
    logic [N*32-1:0] s_wdata;
    logic [N*4-1:0]  s_wstrb;
    logic [N-1:0]    s_wlast;
    logic [N-1:0]    s_bvalid, s_bready;
    logic [1:0]      s_bresp;

    logic        m_arvalid, m_arready;
    logic [3:0]  m_arid, m_arlen, m_arcache;
    logic [31:0] m_araddr;
    logic [2:0]  m_arsize, m_arprot;
    logic [1:0]  m_arburst, m_arlock;
    logic        m_rvalid, m_rready, m_rlast;
    logic [3:0]  m_rid;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;
    logic        m_awvalid, m_awready;
    logic [3:0]  m_awid, m_awlen, m_awcache;
    logic [31:0] m_awaddr;
    logic [2:0]  m_awsize, m_awprot;
    logic [1:0]  m_awburst, m_awlock;
    logic        m_wvalid, m_wready, m_wlast;
    logic [3:0]  m_wid, m_wstrb;
    logic [31:0] m_wdata;
    logic        m_bvalid, m_bready;
    logic [3:0]  m_bid;
    logic [1:0]  m_bresp;

    modport master (
        input  s_arvalid, s_araddr, s_arlen, s_arsize, s_rready,
        input  s_awvalid, s_awaddr, s_awlen, s_awsize,
        input  s_wvalid, s_wdata, s_wstrb, s_wlast, s_bready,
        input  m_arready, m_rvalid, m_rid, m_rdata, m_rresp, m_rlast,
        input  m_awready, m_wready, m_bvalid, m_bid, m_bresp,
        output s_arready, s_rvalid, s_rdata, s_rresp, s_rlast,
        output s_awready, s_wready, s_bvalid, s_bresp,
        output m_arvalid, m_arid, m_araddr, m_arlen, m_arsize,
        output m_arburst, m_arlock, m_arcache, m_arprot, m_rready,
        output m_awvalid, m_awid, m_awaddr, m_awlen, m_awsize,
        output m_awburst, m_awlock, m_awcache, m_awprot,
        output m_wvalid, m_wid, m_wdata, m_wstrb, m_wlast, m_bready
    );

    modport slave (
        output s_arvalid, s_araddr, s_arlen, s_arsize, s_rready,
        output s_awvalid, s_awaddr, s_awlen, s_awsize,
        output s_wvalid, s_wdata, s_wstrb, s_wlast, s_bready,
        output m_arready, m_rvalid, m_rid, m_rdata, m_rresp, m_rlast,
        output m_awready, m_wready, m_bvalid, m_bid, m_bresp,
        input  s_arready, s_rvalid, s_rdata, s_rresp, s_rlast,
        input  s_awready, s_wready, s_bvalid, s_bresp,
        input  m_arvalid, m_arid, m_araddr, m_arlen, m_arsize,
        input  m_arburst, m_arlock, m_arcache, m_arprot, m_rready,
        input  m_awvalid, m_awid, m_awaddr, m_awlen, m_awsize,
        input  m_awburst, m_awlock, m_awcache, m_awprot,
        input  m_wvalid, m_wid, m_wdata, m_wstrb, m_wlast, m_bready
    );
endinterface

// File: rtl/axi_master_arbiter.sv
// Shares one AXI3 master port between N requesters: round-robin AR/AW arbitration, requester
// index used as the downstream ID, R/B responses routed back by ID. One write in flight.
module axi_master_arbiter #(
    parameter int unsigned N       = 2,
    parameter int unsigned MAX_OUT = 4
) (
    input logic                  clk,
    input logic                  rst,
    axi_master_arbiter_if.master bus_io
);
    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CntW = $clog2(MAX_OUT + 1);

    typedef enum logic {ArIdle, ArBusy} ar_state_e;
    typedef enum logic [1:0] {WIdle, WAddr, WData, WResp} w_state_e;

    // First requester at or after ptr, wrapping.
    function automatic logic [IdxW-1:0] rr_pick(input logic [N-1:0] req,
                                                input logic [IdxW-1:0] ptr);
        logic [IdxW-1:0] pick;
        logic            found;
        pick  = ptr;
        found = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            int unsigned idx;
            idx = (32'(ptr) + k) % N;
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = IdxW'(idx);
            end
        end
        return pick;
    endfunction

    function automatic logic [IdxW-1:0] rr_next(input logic [IdxW-1:0] g);
        return (32'(g) == N - 1) ? '0 : g + IdxW'(1);
    endfunction

    ar_state_e       ar_state_q, ar_state_d;
    logic [IdxW-1:0] ar_grant_q, ar_grant_d, ar_ptr_q, ar_ptr_d;
    logic [31:0]     ar_addr_q, ar_addr_d;
    logic [3:0]      ar_len_q, ar_len_d;
    logic [2:0]      ar_size_q, ar_size_d;
    logic [CntW-1:0] out_cnt_q [N];
    logic [CntW-1:0] out_cnt_d [N];
    logic [N-1:0]    ar_elig, cnt_inc, cnt_dec;
    logic            ar_latch;

    w_state_e        w_state_q, w_state_d;
    logic [IdxW-1:0] w_grant_q, w_grant_d, w_ptr_q, w_ptr_d;
    logic [31:0]     aw_addr_q, aw_addr_d;
    logic [3:0]      aw_len_q, aw_len_d;
    logic [2:0]      aw_size_q, aw_size_d;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            ar_elig[i] = bus_io.s_arvalid[i] && (32'(out_cnt_q[i]) < MAX_OUT);
        end
        ar_state_d       = ar_state_q;
        ar_grant_d       = ar_grant_q;
        ar_ptr_d         = ar_ptr_q;
        ar_addr_d        = ar_addr_q;
        ar_len_d         = ar_len_q;
        ar_size_d        = ar_size_q;
        ar_latch         = 1'b0;
        bus_io.s_arready = '0;
        bus_io.m_arvalid = 1'b0;
        unique case (ar_state_q)
            ArIdle: begin
                if (|ar_elig && !rst) begin
                    ar_latch   = 1'b1;
                    ar_grant_d = rr_pick(ar_elig, ar_ptr_q);
                    ar_addr_d  = bus_io.s_araddr[32*ar_grant_d +: 32];
                    ar_len_d   = bus_io.s_arlen[4*ar_grant_d +: 4];
                    ar_size_d  = bus_io.s_arsize[3*ar_grant_d +: 3];
                    bus_io.s_arready[ar_grant_d] = 1'b1;
                    ar_state_d = ArBusy;
                end
            end
            ArBusy: begin
                bus_io.m_arvalid = 1'b1;
                if (bus_io.m_arready) begin
                    ar_ptr_d   = rr_next(ar_grant_q);
                    ar_state_d = ArIdle;
                end
            end
            default: ar_state_d = ArIdle;
        endcase
    end

    // Counter saturates via eligibility gating; a stray rlast never underflows it.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            cnt_inc[i]   = ar_latch && (ar_grant_d == IdxW'(i));
            cnt_dec[i]   = bus_io.m_rvalid && bus_io.m_rready && bus_io.m_rlast &&
                           (bus_io.m_rid == 4'(i)) && (out_cnt_q[i] != '0);
            out_cnt_d[i] = out_cnt_q[i];
            if (cnt_inc[i] && !cnt_dec[i]) begin
                out_cnt_d[i] = out_cnt_q[i] + CntW'(1);
            end else if (cnt_dec[i] && !cnt_inc[i]) begin
                out_cnt_d[i] = out_cnt_q[i] - CntW'(1);
            end
        end
    end

    // Responses for unknown IDs are swallowed.
    always_comb begin
        bus_io.m_rready = !rst;
        bus_io.s_rvalid = '0;
        bus_io.m_bready = !rst;
        bus_io.s_bvalid = '0;
        for (int i = 0; i < N; i++) begin
            if (bus_io.m_rid == 4'(i)) begin
                bus_io.m_rready    = bus_io.s_rready[i] && !rst;
                bus_io.s_rvalid[i] = bus_io.m_rvalid && !rst;
            end
            if (bus_io.m_bid == 4'(i)) begin
                bus_io.m_bready    = bus_io.s_bready[i] && !rst;
                bus_io.s_bvalid[i] = bus_io.m_bvalid && !rst;
            end
        end
    end

    always_comb begin
        w_state_d        = w_state_q;
        w_grant_d        = w_grant_q;
        w_ptr_d          = w_ptr_q;
        aw_addr_d        = aw_addr_q;
        aw_len_d         = aw_len_q;
        aw_size_d        = aw_size_q;
        bus_io.s_awready = '0;
        bus_io.m_awvalid = 1'b0;
        bus_io.m_wvalid  = 1'b0;
        bus_io.m_wdata   = '0;
        bus_io.m_wstrb   = '0;
        bus_io.m_wlast   = 1'b0;
        bus_io.s_wready  = '0;
        unique case (w_state_q)
            WIdle: begin
                if (|bus_io.s_awvalid && !rst) begin
                    w_grant_d = rr_pick(bus_io.s_awvalid, w_ptr_q);
                    aw_addr_d = bus_io.s_awaddr[32*w_grant_d +: 32];
                    aw_len_d  = bus_io.s_awlen[4*w_grant_d +: 4];
                    aw_size_d = bus_io.s_awsize[3*w_grant_d +: 3];
                    bus_io.s_awready[w_grant_d] = 1'b1;
                    w_state_d = WAddr;
                end
            end
            WAddr: begin
                bus_io.m_awvalid = 1'b1;
                if (bus_io.m_awready) begin
                    w_ptr_d   = rr_next(w_grant_q);
                    w_state_d = WData;
                end
            end
            WData: begin
                bus_io.m_wvalid            = bus_io.s_wvalid[w_grant_q];
                bus_io.m_wdata             = bus_io.s_wdata[32*w_grant_q +: 32];
                bus_io.m_wstrb             = bus_io.s_wstrb[4*w_grant_q +: 4];
                bus_io.m_wlast             = bus_io.s_wlast[w_grant_q];
                bus_io.s_wready[w_grant_q] = bus_io.m_wready;
                if (bus_io.s_wvalid[w_grant_q] && bus_io.m_wready &&
                    bus_io.s_wlast[w_grant_q]) begin
                    w_state_d = WResp;
                end
            end
            WResp: begin
                if (bus_io.m_bvalid && bus_io.m_bready) begin
                    w_state_d = WIdle;
                end
            end
            default: w_state_d = WIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ar_state_q <= ArIdle;
            ar_grant_q <= '0;
            ar_ptr_q   <= '0;
            ar_addr_q  <= '0;
            ar_len_q   <= '0;
            ar_size_q  <= '0;
            for (int i = 0; i < N; i++) out_cnt_q[i] <= '0;
            w_state_q  <= WIdle;
            w_grant_q  <= '0;
            w_ptr_q    <= '0;
            aw_addr_q  <= '0;
            aw_len_q   <= '0;
            aw_size_q  <= '0;
        end else begin
            ar_state_q <= ar_state_d;
            ar_grant_q <= ar_grant_d;
            ar_ptr_q   <= ar_ptr_d;
            ar_addr_q  <= ar_addr_d;
            ar_len_q   <= ar_len_d;
            ar_size_q  <= ar_size_d;
            for (int i = 0; i < N; i++) out_cnt_q[i] <= out_cnt_d[i];
            w_state_q  <= w_state_d;
            w_grant_q  <= w_grant_d;
            w_ptr_q    <= w_ptr_d;
            aw_addr_q  <= aw_addr_d;
            aw_len_q   <= aw_len_d;
            aw_size_q  <= aw_size_d;
        end
    end

    assign bus_io.m_arid    = 4'(ar_grant_q);
    assign bus_io.m_araddr  = ar_addr_q;
    assign bus_io.m_arlen   = ar_len_q;
    assign bus_io.m_arsize  = ar_size_q;
    assign bus_io.m_arburst = 2'b01;
    assign bus_io.m_arlock  = '0;
    assign bus_io.m_arcache = '0;
    assign bus_io.m_arprot  = '0;
    assign bus_io.m_awid    = 4'(w_grant_q);
    assign bus_io.m_awaddr  = aw_addr_q;
    assign bus_io.m_awlen   = aw_len_q;
    assign bus_io.m_awsize  = aw_size_q;
    assign bus_io.m_awburst = 2'b01;
    assign bus_io.m_awlock  = '0;
    assign bus_io.m_awcache = '0;
    assign bus_io.m_awprot  = '0;
    assign bus_io.m_wid     = 4'(w_grant_q);
    assign bus_io.s_rdata   = bus_io.m_rdata;
    assign bus_io.s_rresp   = bus_io.m_rresp;
    assign bus_io.s_rlast   = bus_io.m_rlast;
    assign bus_io.s_bresp   = bus_io.m_bresp;
endmodule

// File: tb/tb_axi_master_arbiter.sv
// Bench for axi_master_arbiter: AR/AW/W scoreboards fed as stimulus is driven and drained by
// negedge monitors, plus direct checks of routing, back-pressure, read limits and async reset.
module tb_axi_master_arbiter;
    localparam int unsigned N = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    axi_master_arbiter_if #(.N(N)) bus ();

    axi_master_arbiter #(.N(N), .MAX_OUT(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus.master)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [35:0] ar_q [$];
    logic [35:0] aw_q [$];
    logic [39:0] w_q  [$];
    logic [35:0] ar_e, aw_e;
    logic [39:0] w_e;
    logic        aw_seen;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (bus.m_arvalid && bus.m_arready) begin
                check_val("ar_burst", 64'(bus.m_arburst), 64'(2'b01));
                if (ar_q.size() == 0) begin
                    check_val("ar_unexpected", 64'(ar_q.size()), 64'd1);
                end else begin
                    ar_e = ar_q.pop_front();
                    check_val("ar_id_addr", 64'({bus.m_arid, bus.m_araddr}), 64'(ar_e));
                end
            end
            if (bus.m_awvalid && bus.m_awready) begin
                aw_seen = 1'b1;
                if (aw_q.size() == 0) begin
                    check_val("aw_unexpected", 64'(aw_q.size()), 64'd1);
                end else begin
                    aw_e = aw_q.pop_front();
                    check_val("aw_id_addr", 64'({bus.m_awid, bus.m_awaddr}), 64'(aw_e));
                end
            end
            if (bus.m_wvalid) check_val("w_after_aw", 64'(aw_seen), 64'd1);
            if (bus.m_wvalid && bus.m_wready) begin
                check_val("w_last", 64'(bus.m_wlast), 64'd1);
                if (w_q.size() == 0) begin
                    check_val("w_unexpected", 64'(w_q.size()), 64'd1);
                end else begin
                    w_e = w_q.pop_front();
                    check_val("w_id_strb_data", 64'({bus.m_wid, bus.m_wstrb, bus.m_wdata}),
                              64'(w_e));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        aw_seen       = 1'b0;
        bus.s_araddr  = '0; bus.s_arlen  = '0; bus.s_arsize = '0;
        bus.s_awaddr  = '0; bus.s_awlen  = '0; bus.s_awsize = '0;
        bus.s_wvalid  = '0; bus.s_wdata  = '0; bus.s_wstrb  = '0; bus.s_wlast = '0;
        bus.m_arready = 1'b0; bus.m_awready = 1'b0; bus.m_wready = 1'b0;
        bus.m_rid     = '0; bus.m_rdata = '0; bus.m_rresp = '0; bus.m_rlast = 1'b0;
        bus.m_bid     = '0; bus.m_bresp = '0;
        // Reset with every request/response input active: nothing may leak through.
        rst           = 1'b1;
        bus.s_arvalid = '1; bus.s_awvalid = '1; bus.s_rready = '1; bus.s_bready = '1;
        bus.m_rvalid  = 1'b1; bus.m_bvalid = 1'b1;
        at_neg();
        check_val("rst_s_arready", 64'(bus.s_arready), 64'd0);
        check_val("rst_s_awready", 64'(bus.s_awready), 64'd0);
        check_val("rst_m_arvalid", 64'(bus.m_arvalid), 64'd0);
        check_val("rst_m_awvalid", 64'(bus.m_awvalid), 64'd0);
        check_val("rst_m_wvalid",  64'(bus.m_wvalid),  64'd0);
        check_val("rst_s_rvalid",  64'(bus.s_rvalid),  64'd0);
        check_val("rst_m_rready",  64'(bus.m_rready),  64'd0);
        check_val("rst_s_bvalid",  64'(bus.s_bvalid),  64'd0);
        check_val("rst_m_bready",  64'(bus.m_bready),  64'd0);
        bus.s_arvalid = '0; bus.s_awvalid = '0; bus.s_rready = '0; bus.s_bready = '0;
        bus.m_rvalid  = 1'b0; bus.m_bvalid = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        // Simultaneous reads, then idx0 re-requests: round-robin must hand idx1 its turn.
        bus.m_arready = 1'b1;
        bus.s_araddr  = {32'hbfc0_0004, 32'h1fc0_0000};
        bus.s_arsize  = {3'd2, 3'd2};
        bus.s_arvalid = 2'b11;
        ar_q.push_back({4'd0, 32'h1fc0_0000});
        ar_q.push_back({4'd1, 32'hbfc0_0004});
        at_neg();
        check_val("t1_grant0", 64'(bus.s_arready), 64'(2'b01));
        tick();
        bus.s_araddr[31:0] = 32'h1fc0_0100;
        ar_q.push_back({4'd0, 32'h1fc0_0100});
        at_neg();
        check_val("t1_busy_no_ready", 64'(bus.s_arready), 64'd0);
        check_val("t1_arvalid", 64'(bus.m_arvalid), 64'd1);
        tick();
        at_neg();
        check_val("t1_grant1", 64'(bus.s_arready), 64'(2'b10));
        tick();
        bus.s_arvalid[1] = 1'b0;
        at_neg();
        tick();
        at_neg();
        check_val("t1_grant0_again", 64'(bus.s_arready), 64'(2'b01));
        tick();
        bus.s_arvalid[0] = 1'b0;
        at_neg();
        tick();

        // R routing by ID; m_rready follows the addressed requester only.
        bus.m_rvalid = 1'b1; bus.m_rid = 4'd1; bus.m_rlast = 1'b1;
        bus.m_rdata  = 32'hcafe_0001; bus.s_rready = 2'b01;
        at_neg();
        check_val("t1_rvalid_id1", 64'(bus.s_rvalid), 64'(2'b10));
        check_val("t1_rready_blocked", 64'(bus.m_rready), 64'd0);
        tick();
        bus.s_rready = 2'b11;
        at_neg();
        check_val("t1_rready_id1", 64'(bus.m_rready), 64'd1);
        check_val("t1_rdata", 64'(bus.s_rdata), 64'h0000_0000_cafe_0001);
        tick();
        bus.m_rid = 4'd0; bus.m_rdata = 32'hcafe_0000;
        at_neg();
        check_val("t1_rvalid_id0", 64'(bus.s_rvalid), 64'(2'b01));
        tick();
        bus.m_rvalid = 1'b0; bus.s_rready = '0;

        // idx1 fills its outstanding-read budget.
        for (int k = 0; k < 4; k++) begin
            bus.s_araddr[63:32] = 32'h8000_0000 + 32'(k * 4);
            bus.s_arvalid[1]    = 1'b1;
            ar_q.push_back({4'd1, 32'h8000_0000 + 32'(k * 4)});
            at_neg();
            check_val("t2_accept", 64'(bus.s_arready[1]), 64'd1);
            tick();
            bus.s_arvalid[1] = 1'b0;
            at_neg();
            tick();
        end
        bus.s_araddr[63:32] = 32'h8000_0010;
        bus.s_arvalid[1]    = 1'b1;
        ar_q.push_back({4'd1, 32'h8000_0010});
        for (int k = 0; k < 3; k++) begin
            at_neg();
            check_val("t2_full", 64'(bus.s_arready[1]), 64'd0);
            check_val("t2_no_arvalid", 64'(bus.m_arvalid), 64'd0);
            tick();
        end

        // Stray rid=3 beat: accepted and dropped, idx1 still full.
        bus.m_rvalid = 1'b1; bus.m_rid = 4'd3; bus.m_rlast = 1'b1;
        at_neg();
        check_val("t5_rready", 64'(bus.m_rready), 64'd1);
        check_val("t5_no_svalid", 64'(bus.s_rvalid), 64'd0);
        tick();
        bus.m_rvalid = 1'b0;
        at_neg();
        check_val("t5_cnt_unchanged", 64'(bus.s_arready[1]), 64'd0);
        tick();

        // One completed read for idx1 frees a slot on the following cycle.
        bus.m_rvalid = 1'b1; bus.m_rid = 4'd1; bus.s_rready = 2'b10;
        at_neg();
        check_val("t2_still_full", 64'(bus.s_arready[1]), 64'd0);
        tick();
        bus.m_rvalid = 1'b0; bus.s_rready = '0;
        at_neg();
        check_val("t2_fifth_accept", 64'(bus.s_arready[1]), 64'd1);
        tick();
        bus.s_arvalid[1] = 1'b0;
        at_neg();
        tick();

        // AR back-pressure: payload held, no second grant until the handshake.
        bus.m_arready      = 1'b0;
        bus.s_araddr[31:0] = 32'h1000_0040;
        bus.s_arvalid[0]   = 1'b1;
        ar_q.push_back({4'd0, 32'h1000_0040});
        at_neg();
        check_val("t3_grant", 64'(bus.s_arready), 64'(2'b01));
        tick();
        bus.s_araddr[31:0] = 32'h2000_0000;
        ar_q.push_back({4'd0, 32'h2000_0000});
        for (int k = 0; k < 5; k++) begin
            at_neg();
            check_val("t3_hold_valid", 64'(bus.m_arvalid), 64'd1);
            check_val("t3_hold_addr", 64'(bus.m_araddr), 64'h0000_0000_1000_0040);
            check_val("t3_no_grant", 64'(bus.s_arready), 64'd0);
            tick();
        end
        bus.m_arready = 1'b1;
        at_neg();
        tick();
        at_neg();
        check_val("t3_second_grant", 64'(bus.s_arready), 64'(2'b01));
        tick();
        bus.s_arvalid[0] = 1'b0;
        at_neg();
        tick();
        check_val("ar_queue_drained", 64'(ar_q.size()), 64'd0);

        // Write from idx0 with late awready; idx1 waits for the B handshake.
        aw_seen        = 1'b0;
        bus.m_awready  = 1'b0;
        bus.m_wready   = 1'b1;
        bus.s_awaddr   = {32'h0000_1000, 32'hbfaf_8000};
        bus.s_awsize   = {3'd2, 3'd2};
        bus.s_wdata    = {32'hdead_beef, 32'h1234_5678};
        bus.s_wstrb    = {4'h3, 4'hf};
        bus.s_wlast    = 2'b11;
        bus.s_wvalid   = 2'b01;
        bus.s_awvalid  = 2'b11;
        aw_q.push_back({4'd0, 32'hbfaf_8000});
        w_q.push_back({4'd0, 4'hf, 32'h1234_5678});
        at_neg();
        check_val("t4_aw_grant", 64'(bus.s_awready), 64'(2'b01));
        tick();
        bus.s_awvalid[0] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            at_neg();
            check_val("t4_no_wvalid_early", 64'(bus.m_wvalid), 64'd0);
            check_val("t4_awvalid", 64'(bus.m_awvalid), 64'd1);
            check_val("t4_idx1_blocked", 64'(bus.s_awready), 64'd0);
            tick();
        end
        bus.m_awready = 1'b1;
        at_neg();
        tick();
        bus.m_awready = 1'b0;
        at_neg();
        check_val("t4_wvalid", 64'(bus.m_wvalid), 64'd1);
        check_val("t4_wready_route", 64'(bus.s_wready), 64'(2'b01));
        tick();
        bus.s_wvalid[0] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            at_neg();
            check_val("t4_resp_block", 64'(bus.s_awready), 64'd0);
            check_val("t4_resp_no_w", 64'(bus.m_wvalid), 64'd0);
            tick();
        end
        bus.m_bvalid = 1'b1; bus.m_bid = 4'd0; bus.m_bresp = 2'b10; bus.s_bready = 2'b01;
        at_neg();
        check_val("t4_bvalid_route", 64'(bus.s_bvalid), 64'(2'b01));
        check_val("t4_bready", 64'(bus.m_bready), 64'd1);
        check_val("t4_bresp", 64'(bus.s_bresp), 64'(2'b10));
        tick();
        bus.m_bvalid = 1'b0; bus.s_bready = '0;
        at_neg();
        check_val("t4_idx1_aw", 64'(bus.s_awready), 64'(2'b10));
        tick();
        bus.s_awvalid[1] = 1'b0;
        aw_seen          = 1'b0;
        aw_q.push_back({4'd1, 32'h0000_1000});

        // Async reset while idx1 sits in the data phase.
        bus.m_awready = 1'b1;
        at_neg();
        tick();
        bus.m_awready = 1'b0;
        bus.m_wready  = 1'b0;
        bus.s_wvalid  = 2'b10;
        at_neg();
        check_val("t6_wvalid", 64'(bus.m_wvalid), 64'd1);
        check_val("t6_wid", 64'(bus.m_wid), 64'd1);
        check_val("t6_wdata", 64'(bus.m_wdata), 64'h0000_0000_dead_beef);
        #1;
        rst           = 1'b1;
        bus.s_awvalid = 2'b10;
        bus.s_arvalid = 2'b10;
        #1;
        check_val("t6_async_wvalid", 64'(bus.m_wvalid), 64'd0);
        check_val("t6_async_swready", 64'(bus.s_wready), 64'd0);
        check_val("t6_async_awready", 64'(bus.s_awready), 64'd0);
        check_val("t6_async_arready", 64'(bus.s_arready), 64'd0);
        tick();
        tick();
        rst          = 1'b0;
        bus.s_wvalid = '0;
        ar_q.push_back({4'd1, 32'h8000_0010});
        aw_q.push_back({4'd1, 32'h0000_1000});
        at_neg();
        check_val("t6_aw_idle", 64'(bus.s_awready), 64'(2'b10));
        check_val("t6_cnt_cleared", 64'(bus.s_arready), 64'(2'b10));
        tick();
        bus.s_awvalid = '0;
        bus.s_arvalid = '0;
        bus.m_awready = 1'b1;
        at_neg();
        tick();
        bus.m_awready = 1'b0;
        check_val("queues_empty", 64'(ar_q.size() + aw_q.size() + w_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
